// File: rtl/branch_predictor.sv
// Branch predictor: 2-bit saturating-counter PHT plus direct-mapped BTB.
// Predictions are registered and appear one cycle after a fetch lookup.
// Resolved outcomes train the tables on the next clock edge. A lookup in the
// same cycle as an update sees the pre-update tables.
// Optional feature: define GSHARE_PREDICTOR_EN to add a global history
// register that is XOR-ed into the PHT index (gshare). Undefined is bimodal.
module branch_predictor #(
  parameter int unsigned WordSize  = 32,
  parameter int unsigned IndexBits = 6
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                f_valid,
  input  logic [WordSize-1:0] f_pc,
  input  logic                upd_valid,
  input  logic [WordSize-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [WordSize-1:0] upd_target,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [WordSize-1:0] pred_pc,
  output logic [WordSize-1:0] pred_addr
);

  localparam int unsigned Entries = 1 << IndexBits;
  localparam int unsigned TagBits = WordSize - IndexBits - 2;

  typedef struct packed {
    logic                valid;
    logic [TagBits-1:0]  tag;
    logic [WordSize-1:0] target;
  } btb_entry_t;

  btb_entry_t btb [Entries];
  logic [1:0] pht [Entries];

  logic [IndexBits-1:0] f_btb_idx_c;
  logic [IndexBits-1:0] f_pht_idx_c;
  logic [TagBits-1:0]   f_tag_c;
  logic [IndexBits-1:0] u_btb_idx_c;
  logic [IndexBits-1:0] u_pht_idx_c;
  logic [TagBits-1:0]   u_tag_c;
  logic                 hit_c;
  logic                 taken_c;
  logic [WordSize-1:0]  addr_c;

  // Word-offset bits of the PCs never participate in indexing or tags.
  logic unused_offset_c;
  assign unused_offset_c = ^{f_pc[1:0], upd_pc[1:0]};

  assign f_btb_idx_c = f_pc[IndexBits+1:2];
  assign f_tag_c     = f_pc[WordSize-1:IndexBits+2];
  assign u_btb_idx_c = upd_pc[IndexBits+1:2];
  assign u_tag_c     = upd_pc[WordSize-1:IndexBits+2];

`ifdef GSHARE_PREDICTOR_EN
  logic [IndexBits-1:0] ghr;

  // Non-speculative global history: shifts in each resolved direction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ghr <= '0;
    end else if (upd_valid) begin
      ghr <= {ghr[IndexBits-2:0], upd_taken};
    end
  end

  assign f_pht_idx_c = f_btb_idx_c ^ ghr;
  assign u_pht_idx_c = u_btb_idx_c ^ ghr;
`else
  assign f_pht_idx_c = f_btb_idx_c;
  assign u_pht_idx_c = u_btb_idx_c;
`endif

  // Lookup: BTB hit plus counter MSB selects the target, else fall through.
  always_comb begin
    hit_c   = 1'b0;
    taken_c = 1'b0;
    addr_c  = f_pc + WordSize'(4);
    hit_c   = btb[f_btb_idx_c].valid && (btb[f_btb_idx_c].tag == f_tag_c);
    taken_c = hit_c && pht[f_pht_idx_c][1];
    if (taken_c) begin
      addr_c = btb[f_btb_idx_c].target;
    end
  end

  // Prediction register: refreshed on a lookup, held otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_pc    <= '0;
      pred_addr  <= '0;
    end else begin
      pred_valid <= f_valid;
      if (f_valid) begin
        pred_taken <= taken_c;
        pred_pc    <= f_pc;
        pred_addr  <= addr_c;
      end
    end
  end

  // PHT training: 2-bit saturating counters, reset to weakly not-taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(Entries); i++) begin
        pht[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_taken && (pht[u_pht_idx_c] != 2'b11)) begin
        pht[u_pht_idx_c] <= pht[u_pht_idx_c] + 2'd1;
      end else if (!upd_taken && (pht[u_pht_idx_c] != 2'b00)) begin
        pht[u_pht_idx_c] <= pht[u_pht_idx_c] - 2'd1;
      end
    end
  end

  // BTB fill on taken branches; overwrites whatever entry aliases there.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(Entries); i++) begin
        btb[i] <= '0;
      end
    end else if (upd_valid && upd_taken) begin
      btb[u_btb_idx_c] <= '{valid: 1'b1, tag: u_tag_c, target: upd_target};
    end
  end

endmodule
